// File: rtl/calendar_pkg.sv
// Shared BCD date helpers: month constants, digit-wise increment/decrement,
// leap-year test and month length lookup on 2-digit BCD values.
package calendar_pkg;

    localparam logic [7:0] JAN = 8'h01;
    localparam logic [7:0] FEB = 8'h02;
    localparam logic [7:0] MAR = 8'h03;
    localparam logic [7:0] APR = 8'h04;
    localparam logic [7:0] MAY = 8'h05;
    localparam logic [7:0] JUN = 8'h06;
    localparam logic [7:0] JUL = 8'h07;
    localparam logic [7:0] AUG = 8'h08;
    localparam logic [7:0] SEP = 8'h09;
    localparam logic [7:0] OCT = 8'h10;
    localparam logic [7:0] NOV = 8'h11;
    localparam logic [7:0] DEC = 8'h12;

    // 99 wraps to 00 so the year counter needs no special case.
    function automatic logic [7:0] bcd_inc(input logic [7:0] v);
        logic [3:0] t;
        logic [3:0] o;
        t = v[7:4];
        o = v[3:0];
        if (o >= 4'd9) begin
            o = 4'd0;
            t = (t >= 4'd9) ? 4'd0 : t + 4'd1;
        end else begin
            o = o + 4'd1;
        end
        return {t, o};
    endfunction

    // 00 wraps to 99.
    function automatic logic [7:0] bcd_dec(input logic [7:0] v);
        logic [3:0] t;
        logic [3:0] o;
        t = v[7:4];
        o = v[3:0];
        if (o == 4'd0) begin
            o = 4'd9;
            t = (t == 4'd0) ? 4'd9 : t - 4'd1;
        end else begin
            o = o - 4'd1;
        end
        return {t, o};
    endfunction

    function automatic logic bcd_valid(input logic [7:0] v);
        return (v[7:4] <= 4'd9) && (v[3:0] <= 4'd9);
    endfunction

    // Divisible by 4 on decimal digits: even tens need ones 0/4/8, odd tens 2/6.
    function automatic logic is_leap(input logic [7:0] y);
        logic [3:0] o;
        o = y[3:0];
        if (!y[4]) begin
            return (o == 4'd0) || (o == 4'd4) || (o == 4'd8);
        end
        return (o == 4'd2) || (o == 4'd6);
    endfunction

    function automatic logic [7:0] days_in_month(input logic [7:0] m,
                                                 input logic [7:0] y,
                                                 input logic       leap_en);
        case (m)
            APR, JUN, SEP, NOV: return 8'h30;
            FEB:                return (leap_en && is_leap(y)) ? 8'h29 : 8'h28;
            default:            return 8'h31;
        endcase
    endfunction

endpackage

// File: rtl/month_length.sv
// Combinational last-day-of-month lookup for a BCD month/year pair.
module month_length
    import calendar_pkg::*;
#(
    parameter logic LEAP_EN = 1'b1
) (
    input  logic [7:0] i_month,
    input  logic [7:0] i_year,
    output logic [7:0] o_last_day
);

    assign o_last_day = days_in_month(i_month, i_year, LEAP_EN);

endmodule

// File: rtl/bcd_calendar.sv
// BCD month/day/year counter with up/down ticking, leap years and a validated
// parallel load; every output comes straight from a register.
module bcd_calendar
    import calendar_pkg::*;
#(
    parameter logic [7:0] START_MONTH = 8'h01,
    parameter logic [7:0] START_DAY   = 8'h01,
    parameter logic [7:0] START_YEAR  = 8'h00,
    parameter logic       LEAP_EN     = 1'b1
) (
    input  logic       clock,
    input  logic       reset_n,
    input  logic       tick,
    input  logic       dir,
    input  logic       load,
    input  logic [7:0] load_month,
    input  logic [7:0] load_day,
    input  logic [7:0] load_year,
    output logic [7:0] month,
    output logic [7:0] day,
    output logic [7:0] year,
    output logic       year_wrap,
    output logic       load_err
);

    logic [7:0] r_month;
    logic [7:0] r_day;
    logic [7:0] r_year;
    logic       r_year_wrap;
    logic       r_load_err;

    logic [7:0] w_prev_month;
    logic [7:0] w_prev_year;
    logic [7:0] w_aux_month;
    logic [7:0] w_aux_year;
    logic [7:0] w_last_cur;
    logic [7:0] w_last_aux;
    logic       w_load_ok;

    assign w_prev_month = (r_month == JAN) ? DEC : bcd_dec(r_month);
    assign w_prev_year  = (r_month == JAN) ? bcd_dec(r_year) : r_year;

    // The second lookup serves load validation, or the month a down tick enters.
    assign w_aux_month = load ? load_month : w_prev_month;
    assign w_aux_year  = load ? load_year  : w_prev_year;

    month_length #(.LEAP_EN(LEAP_EN)) u_len_cur (
        .i_month    (r_month),
        .i_year     (r_year),
        .o_last_day (w_last_cur)
    );

    month_length #(.LEAP_EN(LEAP_EN)) u_len_aux (
        .i_month    (w_aux_month),
        .i_year     (w_aux_year),
        .o_last_day (w_last_aux)
    );

    assign w_load_ok = bcd_valid(load_month) && bcd_valid(load_day) && bcd_valid(load_year)
                    && (load_month >= JAN) && (load_month <= DEC)
                    && (load_day >= 8'h01) && (load_day <= w_last_aux);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_month     <= START_MONTH;
            r_day       <= START_DAY;
            r_year      <= START_YEAR;
            r_year_wrap <= 1'b0;
            r_load_err  <= 1'b0;
        end else begin
            r_year_wrap <= 1'b0;
            r_load_err  <= 1'b0;
            if (load) begin
                if (w_load_ok) begin
                    r_month <= load_month;
                    r_day   <= load_day;
                    r_year  <= load_year;
                end else begin
                    r_load_err <= 1'b1;
                end
            end else if (tick) begin
                if (!dir) begin
                    if (r_day < w_last_cur) begin
                        r_day <= bcd_inc(r_day);
                    end else begin
                        r_day <= 8'h01;
                        if (r_month == DEC) begin
                            r_month     <= JAN;
                            r_year      <= bcd_inc(r_year);
                            r_year_wrap <= (r_year == 8'h99);
                        end else begin
                            r_month <= bcd_inc(r_month);
                        end
                    end
                end else begin
                    if (r_day > 8'h01) begin
                        r_day <= bcd_dec(r_day);
                    end else begin
                        r_month     <= w_prev_month;
                        r_year      <= w_prev_year;
                        r_day       <= w_last_aux;
                        r_year_wrap <= (r_month == JAN) && (r_year == 8'h00);
                    end
                end
            end
        end
    end

    assign month     = r_month;
    assign day       = r_day;
    assign year      = r_year;
    assign year_wrap = r_year_wrap;
    assign load_err  = r_load_err;

endmodule

// File: tb/tb_bcd_calendar.sv
// Directed table-driven bench for bcd_calendar, plus hand sequences for
// asynchronous reset and the LEAP_EN=0 variant.
module tb_bcd_calendar;

    logic       clock = 1'b0;
    logic       reset_n = 1'b0;
    logic       tick = 1'b0;
    logic       dir = 1'b0;
    logic       load = 1'b0;
    logic [7:0] load_month = 8'h00;
    logic [7:0] load_day = 8'h00;
    logic [7:0] load_year = 8'h00;

    logic [7:0] month, day, year;
    logic       year_wrap, load_err;
    logic [7:0] month1, day1, year1;
    logic       year_wrap1, load_err1;

    int n_pass = 0;
    int n_total = 0;

    always #5 clock = ~clock;

    bcd_calendar dut (
        .clock(clock), .reset_n(reset_n), .tick(tick), .dir(dir), .load(load),
        .load_month(load_month), .load_day(load_day), .load_year(load_year),
        .month(month), .day(day), .year(year),
        .year_wrap(year_wrap), .load_err(load_err)
    );

    bcd_calendar #(.LEAP_EN(1'b0)) dut_noleap (
        .clock(clock), .reset_n(reset_n), .tick(tick), .dir(dir), .load(load),
        .load_month(load_month), .load_day(load_day), .load_year(load_year),
        .month(month1), .day(day1), .year(year1),
        .year_wrap(year_wrap1), .load_err(load_err1)
    );

    typedef struct {
        string      name;
        logic       ld;
        logic       tk;
        logic       dr;
        logic [7:0] lm;
        logic [7:0] lday;
        logic [7:0] ly;
        logic [7:0] em;
        logic [7:0] ed;
        logic [7:0] ey;
        logic       ew;
        logic       ee;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input string name, input logic ld, input logic tk, input logic dr,
                       input logic [7:0] lm, input logic [7:0] lday, input logic [7:0] ly,
                       input logic [7:0] em, input logic [7:0] ed, input logic [7:0] ey,
                       input logic ew, input logic ee);
        vec_t v;
        v.name = name; v.ld = ld; v.tk = tk; v.dr = dr;
        v.lm = lm; v.lday = lday; v.ly = ly;
        v.em = em; v.ed = ed; v.ey = ey; v.ew = ew; v.ee = ee;
        vecs.push_back(v);
    endtask

    task automatic check(input string name,
                         input logic [7:0] am, input logic [7:0] ad, input logic [7:0] ay,
                         input logic aw, input logic ae,
                         input logic [7:0] em, input logic [7:0] ed, input logic [7:0] ey,
                         input logic ew, input logic ee);
        n_total++;
        if (am === em && ad === ed && ay === ey && aw === ew && ae === ee) begin
            n_pass++;
            $display("ok   %-20s %h/%h/%h wrap=%b err=%b", name, am, ad, ay, aw, ae);
        end else begin
            $display("FAIL %-20s got %h/%h/%h wrap=%b err=%b expected %h/%h/%h wrap=%b err=%b",
                     name, am, ad, ay, aw, ae, em, ed, ey, ew, ee);
        end
    endtask

    task automatic step(input logic ld, input logic tk, input logic dr,
                        input logic [7:0] lm, input logic [7:0] lday, input logic [7:0] ly);
        load = ld; tick = tk; dir = dr;
        load_month = lm; load_day = lday; load_year = ly;
        @(posedge clock);
        #1;
        load = 1'b0;
        tick = 1'b0;
    endtask

    initial begin
        //   name                ld tk dr  lm     ld     ly     em     ed     ey    w  e
        add("idle_after_reset",  0, 0, 0, 8'h00, 8'h00, 8'h00, 8'h01, 8'h01, 8'h00, 0, 0);
        add("load_0228_24",      1, 0, 0, 8'h02, 8'h28, 8'h24, 8'h02, 8'h28, 8'h24, 0, 0);
        add("up_to_0229_24",     0, 1, 0, 8'h00, 8'h00, 8'h00, 8'h02, 8'h29, 8'h24, 0, 0);
        add("up_to_0301_24",     0, 1, 0, 8'h00, 8'h00, 8'h00, 8'h03, 8'h01, 8'h24, 0, 0);
        add("load_0228_23",      1, 0, 0, 8'h02, 8'h28, 8'h23, 8'h02, 8'h28, 8'h23, 0, 0);
        add("up_to_0301_23",     0, 1, 0, 8'h00, 8'h00, 8'h00, 8'h03, 8'h01, 8'h23, 0, 0);
        add("load_1231_99",      1, 0, 0, 8'h12, 8'h31, 8'h99, 8'h12, 8'h31, 8'h99, 0, 0);
        add("up_century_wrap",   0, 1, 0, 8'h00, 8'h00, 8'h00, 8'h01, 8'h01, 8'h00, 1, 0);
        add("wrap_pulse_ends",   0, 0, 0, 8'h00, 8'h00, 8'h00, 8'h01, 8'h01, 8'h00, 0, 0);
        add("down_century_wrap", 0, 1, 1, 8'h00, 8'h00, 8'h00, 8'h12, 8'h31, 8'h99, 1, 0);
        add("wrap_pulse_ends2",  0, 0, 1, 8'h00, 8'h00, 8'h00, 8'h12, 8'h31, 8'h99, 0, 0);
        add("load_0301_24",      1, 0, 1, 8'h03, 8'h01, 8'h24, 8'h03, 8'h01, 8'h24, 0, 0);
        add("down_to_0229_24",   0, 1, 1, 8'h00, 8'h00, 8'h00, 8'h02, 8'h29, 8'h24, 0, 0);
        add("load_0501_24",      1, 0, 1, 8'h05, 8'h01, 8'h24, 8'h05, 8'h01, 8'h24, 0, 0);
        add("down_to_0430_24",   0, 1, 1, 8'h00, 8'h00, 8'h00, 8'h04, 8'h30, 8'h24, 0, 0);
        add("load_0110_24",      1, 0, 1, 8'h01, 8'h10, 8'h24, 8'h01, 8'h10, 8'h24, 0, 0);
        add("down_borrow_0109",  0, 1, 1, 8'h00, 8'h00, 8'h00, 8'h01, 8'h09, 8'h24, 0, 0);
        add("bad_0230_24",       1, 0, 0, 8'h02, 8'h30, 8'h24, 8'h01, 8'h09, 8'h24, 0, 1);
        add("err_pulse_ends",    0, 0, 0, 8'h00, 8'h00, 8'h00, 8'h01, 8'h09, 8'h24, 0, 0);
        add("bad_1301_24",       1, 0, 0, 8'h13, 8'h01, 8'h24, 8'h01, 8'h09, 8'h24, 0, 1);
        add("err_pulse_ends2",   0, 0, 0, 8'h00, 8'h00, 8'h00, 8'h01, 8'h09, 8'h24, 0, 0);
        add("bad_041A_24",       1, 0, 0, 8'h04, 8'h1A, 8'h24, 8'h01, 8'h09, 8'h24, 0, 1);
        add("bad_0400_24",       1, 0, 0, 8'h04, 8'h00, 8'h24, 8'h01, 8'h09, 8'h24, 0, 1);
        add("load_wins_tick",    1, 1, 0, 8'h06, 8'h15, 8'h50, 8'h06, 8'h15, 8'h50, 0, 0);
        add("up_to_0616_50",     0, 1, 0, 8'h00, 8'h00, 8'h00, 8'h06, 8'h16, 8'h50, 0, 0);
        add("load_0109_24",      1, 0, 0, 8'h01, 8'h09, 8'h24, 8'h01, 8'h09, 8'h24, 0, 0);
        add("up_carry_0110",     0, 1, 0, 8'h00, 8'h00, 8'h00, 8'h01, 8'h10, 8'h24, 0, 0);
        add("load_0101_25",      1, 0, 1, 8'h01, 8'h01, 8'h25, 8'h01, 8'h01, 8'h25, 0, 0);
        add("down_to_1231_24",   0, 1, 1, 8'h00, 8'h00, 8'h00, 8'h12, 8'h31, 8'h24, 0, 0);
        add("load_0301_23",      1, 0, 1, 8'h03, 8'h01, 8'h23, 8'h03, 8'h01, 8'h23, 0, 0);
        add("down_to_0228_23",   0, 1, 1, 8'h00, 8'h00, 8'h00, 8'h02, 8'h28, 8'h23, 0, 0);

        // Reset held across edges, checked before release.
        repeat (2) @(posedge clock);
        #1;
        check("reset_state", month, day, year, year_wrap, load_err,
              8'h01, 8'h01, 8'h00, 1'b0, 1'b0);
        @(negedge clock);
        reset_n = 1'b1;
        @(posedge clock);
        #1;

        foreach (vecs[i]) begin
            step(vecs[i].ld, vecs[i].tk, vecs[i].dr, vecs[i].lm, vecs[i].lday, vecs[i].ly);
            check(vecs[i].name, month, day, year, year_wrap, load_err,
                  vecs[i].em, vecs[i].ed, vecs[i].ey, vecs[i].ew, vecs[i].ee);
        end

        // LEAP_EN=0 skips 02/29 even in a leap year.
        step(1'b1, 1'b0, 1'b0, 8'h02, 8'h28, 8'h24);
        step(1'b0, 1'b1, 1'b0, 8'h00, 8'h00, 8'h00);
        check("noleap_0301_24", month1, day1, year1, year_wrap1, load_err1,
              8'h03, 8'h01, 8'h24, 1'b0, 1'b0);
        check("leap_same_input", month, day, year, year_wrap, load_err,
              8'h02, 8'h29, 8'h24, 1'b0, 1'b0);

        // Asynchronous reset mid-run with a tick pending, then first tick honoured.
        step(1'b1, 1'b0, 1'b0, 8'h07, 8'h15, 8'h42);
        check("load_0715_42", month, day, year, year_wrap, load_err,
              8'h07, 8'h15, 8'h42, 1'b0, 1'b0);
        tick = 1'b1;
        #2;
        reset_n = 1'b0;
        #1;
        check("async_reset_now", month, day, year, year_wrap, load_err,
              8'h01, 8'h01, 8'h00, 1'b0, 1'b0);
        @(posedge clock);
        #1;
        check("reset_holds_edge", month, day, year, year_wrap, load_err,
              8'h01, 8'h01, 8'h00, 1'b0, 1'b0);
        @(negedge clock);
        reset_n = 1'b1;
        @(posedge clock);
        #1;
        tick = 1'b0;
        check("first_tick_after", month, day, year, year_wrap, load_err,
              8'h01, 8'h02, 8'h00, 1'b0, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/bcd_calendar.md
# bcd_calendar

Parametrised BCD date counter that advances a month/day/year on a single-cycle tick enable. It supports up/down counting, leap years and a validated parallel load. It sits between the clock-divider tick and the seven-segment digit drivers and supersedes the fixed month/day calendar. Outputs are individual BCD digits ready for direct per-digit display decoding.

## Interface

Parameters:
- START_MONTH, 8'h01: reset month, 2-digit BCD, 01–12.
- START_DAY, 8'h01: reset day, 2-digit BCD, must be valid for START_MONTH/START_YEAR.
- START_YEAR, 8'h00: reset year, 2-digit BCD, 00–99.
- LEAP_EN, 1: 1 = February has 29 days in leap years; 0 = February always 28.

Ports:
- clock  in  1  system clock; all state changes on rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- tick  in  1  single-cycle advance enable.
- dir  in  1  0 = count up, 1 = count down; sampled with tick.
- load  in  1  single-cycle load strobe.
- load_month  in  8  BCD month for load.
- load_day  in  8  BCD day for load.
- load_year  in  8  BCD year for load.
- month  out  8  current month, BCD {tens, ones}.
- day  out  8  current day, BCD {tens, ones}.
- year  out  8  current year, BCD {tens, ones}.
- year_wrap  out  1  one-cycle pulse on century wrap.
- load_err  out  1  one-cycle pulse when a load is rejected.

## Operation

- Reset: month=START_MONTH, day=START_DAY, year=START_YEAR, year_wrap=0, load_err=0.
- All outputs are registered. No combinational path exists from inputs to outputs.
- Priority per cycle: load > tick. Simultaneous load and tick: the load is applied and the tick is dropped.
- Load validation: each nibble must be ≤9. Month must be 01–12. Day must be 01 to days_in_month(load_month, load_year).
  - Valid load: all three fields are replaced.
  - Invalid load: state is unchanged and load_err pulses.
- Days in month: 31 for 01,03,05,07,08,10,12. 30 for 04,06,09,11. February is 29 if LEAP_EN and the year is a leap year, else 28.
- Leap year test on BCD digits: if tens is even, ones ∈ {0,4,8}; if tens is odd, ones ∈ {2,6}. Year 00 counts as a leap year.
- Up tick:
  - If day < last day of month: day+1 with BCD carry (09→10, 19→20, 29→30).
  - Else: day=01 and month+1.
  - Month 12 rolls to 01 and year+1.
  - Year 99 rolls to 00 and year_wrap pulses.
- Down tick:
  - If day > 01: day−1 with BCD borrow (10→09, 20→19, 30→29).
  - Else: month−1 and day=last day of the new month (using the new year when crossing January).
  - Month 01 rolls to 12 and year−1.
  - Year 00 rolls to 99 and year_wrap pulses.
- year_wrap and load_err are never asserted in the same cycle.

## Timing

- Latency: a tick or load sampled at edge N is visible on the outputs after edge N. Single-cycle update, no stall.
- A back-to-back tick on every cycle is legal. Each one advances exactly one day.
- year_wrap and load_err are high for exactly the cycle following the causing edge.
- Asynchronous reset forces reset values immediately, regardless of a tick or load in flight. The first tick after reset_n deasserts is honoured.
- dir is sampled only when tick=1. A direction change between ticks needs no idle cycle.

## Structure

- Shared package calendar_pkg:
  - Month BCD constants (JAN…DEC).
  - BCD increment/decrement functions with carry/borrow.
  - is_leap function on BCD year.
  - days_in_month function (month, year, leap_en) returning the BCD last day.
- Natural sub-module: month_length. Combinational; takes month, year and LEAP_EN; returns the BCD last day. Instantiated twice, once for the current date and once for load validation and the down-count new month.

## Test plan

- Reset with defaults → 01/01/00, year_wrap=0, load_err=0. Assert reset_n low mid-run at 07/15/42 → outputs return to 01/01/00 without waiting for a clock edge.
- Load 02/28/24, tick up ×2 → 02/29/24 then 03/01/24. Load 02/28/23, tick up → 03/01/23. With LEAP_EN=0, load 02/28/24, tick up → 03/01/24.
- Load 12/31/99, tick up → 01/01/00 with year_wrap high for one cycle. Then dir=1, tick → 12/31/99 with year_wrap high again.
- dir=1: load 03/01/24, tick → 02/29/24. Load 05/01/24, tick → 04/30/24. Load 01/10/24, tick → 01/09/24 (BCD borrow).
- Load 02/30/24, 13/01/24 and 04/1A/24 in turn → each leaves the state unchanged and pulses load_err once.
- Load 06/15/50 and tick in the same cycle → 06/15/50 (tick dropped). Next tick up → 06/16/50.
